// File: rtl/ofdm_subcarrier_mapper.sv
// rtl/ofdm_subcarrier_mapper.sv - OFDM subcarrier mapper (null/pilot/data bins); optional macro PILOT_SCRAMBLE_EN
module ofdm_subcarrier_mapper #(
    parameter int              DW         = 16,
    parameter int              NFFT       = 64,
    parameter logic [NFFT-1:0] NULL_MASK  = 64'h0000003F_F8000001,
    parameter logic [NFFT-1:0] PILOT_MASK = 64'h02000800_00200080,
    parameter logic [NFFT-1:0] PILOT_POL  = 64'h00000000_00200000,
    parameter logic [DW-1:0]   PILOT_AMP  = 16'h7FFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [2*DW-1:0] s_axis_tdata,
    input  logic            s_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [2*DW-1:0] m_axis_tdata,
    output logic            m_axis_tuser,
    output logic            m_axis_tlast,
    output logic            pad_err
);

    localparam int KW = $clog2(NFFT);
    localparam int CW = KW + 1;

    function automatic int count_data_bins();
        int n;
        n = 0;
        for (int i = 0; i < NFFT; i++) begin
            if (!NULL_MASK[i] && !PILOT_MASK[i]) n = n + 1;
        end
        return n;
    endfunction

    // Number of data bins per symbol; the last one marks a legal packet end
    localparam int            N_DATA        = count_data_bins();
    localparam logic [CW-1:0] LAST_DATA_IDX = CW'(N_DATA - 1);
    localparam logic [KW-1:0] LAST_BIN      = KW'(NFFT - 1);
    localparam logic [DW-1:0] AMP_NEG       = ~PILOT_AMP + {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAP  = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_dcnt;
    logic            r_got_last;
    logic            r_m_tvalid;
    logic [2*DW-1:0] r_m_tdata;
    logic            r_m_tuser;
    logic            r_m_tlast;
    logic            r_pad_err;

    logic            w_load;
    logic            w_is_null;
    logic            w_is_pilot;
    logic            w_is_data;
    logic            w_p;
    logic            w_neg;
    logic            w_in_hs;
    logic            w_in_last;
    logic            w_step;
    logic            w_sym_end;
    logic            w_pkt_end;
    logic            w_early_last;
    logic [2*DW-1:0] w_bin_val;

    // Output slot is free when empty or being drained this cycle
    assign w_load     = !r_m_tvalid || m_axis_tready;

    assign w_is_null  = NULL_MASK[r_k];
    assign w_is_pilot = PILOT_MASK[r_k];
    assign w_is_data  = !w_is_null && !w_is_pilot;

    // Input is only pulled on data bins while mapping live data
    assign s_axis_tready = (r_state == S_MAP) && w_is_data && w_load;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_in_last     = w_in_hs && s_axis_tlast;

    assign w_neg         = PILOT_POL[r_k] ^ w_p;

    // Decide whether the current bin is produced this cycle and its value
    always_comb begin
        w_step    = 1'b0;
        w_bin_val = '0;
        case (r_state)
            S_IDLE:  w_step = w_load && s_axis_tvalid && !w_is_data;
            S_MAP:   w_step = w_load && (!w_is_data || s_axis_tvalid);
            S_PAD:   w_step = w_load;
            default: w_step = 1'b0;
        endcase
        if (w_is_pilot) begin
            w_bin_val = {{DW{1'b0}}, (w_neg ? AMP_NEG : PILOT_AMP)};
        end else if (w_is_data && (r_state == S_MAP)) begin
            w_bin_val = s_axis_tdata;
        end
    end

    assign w_sym_end    = w_step && (r_k == LAST_BIN);
    assign w_pkt_end    = w_sym_end && ((r_state == S_PAD) || r_got_last || w_in_last);
    assign w_early_last = w_in_last && (r_dcnt != LAST_DATA_IDX);

`ifdef PILOT_SCRAMBLE_EN
    logic [6:0] r_lfsr;

    assign w_p = r_lfsr[6] ^ r_lfsr[3];

    // Pilot scrambler x^7+x^4+1: one step per symbol, reseeded when a packet closes
    always_ff @(posedge clk) begin
        if (rst || w_pkt_end) begin
            r_lfsr <= 7'h7F;
        end else if (w_sym_end) begin
            r_lfsr <= {r_lfsr[5:0], w_p};
        end
    end
`else
    assign w_p = 1'b0;
`endif

    // Mapping FSM with bin counter and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_dcnt     <= '0;
            r_got_last <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_pad_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_m_tvalid <= w_step;
                if (w_step) begin
                    r_m_tdata <= w_bin_val;
                    r_m_tuser <= w_sym_end;
                    r_m_tlast <= w_pkt_end;
                end
            end

            // Bin index wraps by itself since NFFT is a power of two
            if (w_step) begin
                r_k <= r_k + 1'b1;
            end

            if (w_in_hs) begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (w_in_last) begin
                r_got_last <= 1'b1;
            end
            if (w_sym_end) begin
                r_dcnt     <= '0;
                r_got_last <= 1'b0;
            end

            if (w_early_last) begin
                r_pad_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (s_axis_tvalid) r_state <= S_MAP;
                end
                S_MAP: begin
                    if (w_early_last)   r_state <= S_PAD;
                    else if (w_pkt_end) r_state <= S_IDLE;
                end
                S_PAD: begin
                    if (w_pkt_end) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign pad_err       = r_pad_err;

endmodule
